// File: rtl/victim_swap_ctrl_pkg.sv
// Shared cache defines for the victim-cache swap controller: default geometry
// and the controller FSM state encoding.
package victim_swap_ctrl_pkg;

  localparam int DCACHE_LINE_WIDTH = 128;
  localparam int VICTIM_ADDR_BITS  = 28;
  localparam int STAT_BITS         = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PROBE,
    ST_EVICT,
    ST_MEM_REQ,
    ST_RESP
  } vsc_state_e;

endpackage

// File: rtl/victim_swap_ctrl.sv
// Victim-cache swap controller: on a dcache miss, probes the victim cache,
// parks the evicted line there, falls back to memory, and refills the dcache.
module victim_swap_ctrl #(
  parameter int DCACHE_LINE_WIDTH = victim_swap_ctrl_pkg::DCACHE_LINE_WIDTH,
  parameter int VICTIM_ADDR_BITS  = victim_swap_ctrl_pkg::VICTIM_ADDR_BITS,
  parameter int STAT_BITS         = victim_swap_ctrl_pkg::STAT_BITS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         miss_req_i,
  output logic                         miss_ready_o,
  input  logic [VICTIM_ADDR_BITS-1:0]  miss_addr_i,
  input  logic                         evict_valid_i,
  input  logic [VICTIM_ADDR_BITS-1:0]  evict_addr_i,
  input  logic [DCACHE_LINE_WIDTH-1:0] evict_data_i,
  output logic [VICTIM_ADDR_BITS-1:0]  victim_addr_o,
  output logic [DCACHE_LINE_WIDTH-1:0] victim_data_o,
  output logic                         victim_write_o,
  input  logic                         victim_hit_i,
  input  logic [DCACHE_LINE_WIDTH-1:0] victim_data_i,
  output logic                         mem_req_o,
  output logic [VICTIM_ADDR_BITS-1:0]  mem_addr_o,
  input  logic                         mem_ack_i,
  input  logic [DCACHE_LINE_WIDTH-1:0] mem_data_i,
  output logic                         fill_valid_o,
  input  logic                         fill_ready_i,
  output logic [VICTIM_ADDR_BITS-1:0]  fill_addr_o,
  output logic [DCACHE_LINE_WIDTH-1:0] fill_data_o,
  output logic                         fill_from_victim_o,
  output logic [STAT_BITS-1:0]         hit_count_o,
  output logic [STAT_BITS-1:0]         miss_count_o
);
  import victim_swap_ctrl_pkg::*;

  vsc_state_e                   r_state;
  vsc_state_e                   w_next;
  logic [VICTIM_ADDR_BITS-1:0]  r_miss_addr;
  logic                         r_ev_valid;
  logic [VICTIM_ADDR_BITS-1:0]  r_ev_addr;
  logic [DCACHE_LINE_WIDTH-1:0] r_ev_data;
  logic                         r_hit;
  logic [DCACHE_LINE_WIDTH-1:0] r_fill_data;
  logic [STAT_BITS-1:0]         r_hit_cnt;
  logic [STAT_BITS-1:0]         r_miss_cnt;
  logic                         w_evict;
  logic                         w_resp;
  logic                         w_memreq;

  // Flush overrides everything, including a same-cycle request in IDLE.
  always_comb begin
    w_next = r_state;
    if (flush_i) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (miss_req_i) w_next = ST_PROBE;
        ST_PROBE:   w_next = r_ev_valid   ? ST_EVICT :
                             victim_hit_i ? ST_RESP  : ST_MEM_REQ;
        ST_EVICT:   w_next = r_hit ? ST_RESP : ST_MEM_REQ;
        ST_MEM_REQ: if (mem_ack_i) w_next = ST_RESP;
        ST_RESP:    if (fill_ready_i) w_next = ST_IDLE;
        default:    w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_miss_addr <= '0;
      r_ev_valid  <= 1'b0;
      r_ev_addr   <= '0;
      r_ev_data   <= '0;
      r_hit       <= 1'b0;
      r_fill_data <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && miss_req_i && !flush_i) begin
        r_miss_addr <= miss_addr_i;
        r_ev_valid  <= evict_valid_i;
        r_ev_addr   <= evict_addr_i;
        r_ev_data   <= evict_data_i;
      end
      // The probe sample is counted even if a flush lands in the same cycle.
      if (r_state == ST_PROBE) begin
        r_hit       <= victim_hit_i;
        r_fill_data <= victim_data_i;
        if (victim_hit_i) r_hit_cnt  <= r_hit_cnt + STAT_BITS'(1);
        else              r_miss_cnt <= r_miss_cnt + STAT_BITS'(1);
      end
      if (r_state == ST_MEM_REQ && mem_ack_i && !flush_i)
        r_fill_data <= mem_data_i;
    end
  end

  assign w_evict  = (r_state == ST_EVICT);
  assign w_resp   = (r_state == ST_RESP);
  assign w_memreq = (r_state == ST_MEM_REQ);

  assign miss_ready_o       = (r_state == ST_IDLE);
  assign victim_write_o     = w_evict;
  assign victim_addr_o      = w_evict ? r_ev_addr : r_miss_addr;
  assign victim_data_o      = w_evict ? r_ev_data : '0;
  assign mem_req_o          = w_memreq;
  assign mem_addr_o         = w_memreq ? r_miss_addr : '0;
  assign fill_valid_o       = w_resp;
  assign fill_addr_o        = w_resp ? r_miss_addr : '0;
  assign fill_data_o        = w_resp ? r_fill_data : '0;
  assign fill_from_victim_o = w_resp & r_hit;
  assign hit_count_o        = r_hit_cnt;
  assign miss_count_o       = r_miss_cnt;

endmodule

// File: tb/tb_victim_swap_ctrl.sv
// Directed bench for victim_swap_ctrl: stimulus pushes expected fills and victim
// writes into queues, a negedge monitor pops and compares them as they appear.
module tb_victim_swap_ctrl;
  localparam int LW = 128;
  localparam int AW = 28;
  localparam int SB = 8;  // narrowed so counter wrap is reachable quickly

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
    logic          src;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush_i = 1'b0;
  logic          miss_req_i = 1'b0;
  logic          miss_ready_o;
  logic [AW-1:0] miss_addr_i = '0;
  logic          evict_valid_i = 1'b0;
  logic [AW-1:0] evict_addr_i = '0;
  logic [LW-1:0] evict_data_i = '0;
  logic [AW-1:0] victim_addr_o;
  logic [LW-1:0] victim_data_o;
  logic          victim_write_o;
  logic          victim_hit_i = 1'b0;
  logic [LW-1:0] victim_data_i = '0;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_ack_i = 1'b0;
  logic [LW-1:0] mem_data_i = '0;
  logic          fill_valid_o;
  logic          fill_ready_i = 1'b0;
  logic [AW-1:0] fill_addr_o;
  logic [LW-1:0] fill_data_o;
  logic          fill_from_victim_o;
  logic [SB-1:0] hit_count_o;
  logic [SB-1:0] miss_count_o;

  victim_swap_ctrl #(.DCACHE_LINE_WIDTH(LW), .VICTIM_ADDR_BITS(AW), .STAT_BITS(SB)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .miss_req_i(miss_req_i), .miss_ready_o(miss_ready_o), .miss_addr_i(miss_addr_i),
    .evict_valid_i(evict_valid_i), .evict_addr_i(evict_addr_i), .evict_data_i(evict_data_i),
    .victim_addr_o(victim_addr_o), .victim_data_o(victim_data_o), .victim_write_o(victim_write_o),
    .victim_hit_i(victim_hit_i), .victim_data_i(victim_data_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .fill_valid_o(fill_valid_o), .fill_ready_i(fill_ready_i), .fill_addr_o(fill_addr_o),
    .fill_data_o(fill_data_o), .fill_from_victim_o(fill_from_victim_o),
    .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   n_memreq = 0;
  ent_t fq[$];
  ent_t wq[$];
  ent_t m_e;

  localparam logic [LW-1:0] DEAD = {4{32'hDEADBEEF}};
  localparam logic [LW-1:0] V1   = {4{32'hCAFEF00D}};
  localparam logic [LW-1:0] E1   = {4{32'h01234567}};
  localparam logic [LW-1:0] V3   = {4{32'h5A5A3C3C}};

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic ev, input logic [AW-1:0] ea,
                       input logic [LW-1:0] ed);
    miss_addr_i = a; evict_valid_i = ev; evict_addr_i = ea; evict_data_i = ed;
    miss_req_i = 1'b1;
    cyc();
    miss_req_i = 1'b0;
  endtask

  task automatic do_hit(input logic [AW-1:0] a, input logic [LW-1:0] d);
    victim_hit_i = 1'b1; victim_data_i = d; fill_ready_i = 1'b1;
    fq.push_back('{addr: a, data: d, src: 1'b1});
    issue(a, 1'b0, '0, '0);
    cyc();
    cyc();
  endtask

  // Monitor: compare every victim write and every fill handshake with the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req_o) n_memreq++;
      if (victim_write_o) begin
        if (wq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexp_vwrite: got write to %0h want none", victim_addr_o);
        end else begin
          m_e = wq.pop_front();
          chk("vwr_addr", LW'(victim_addr_o), LW'(m_e.addr));
          chk("vwr_data", victim_data_o, m_e.data);
        end
      end
      if (fill_valid_o && fill_ready_i) begin
        if (fq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexp_fill: got fill to %0h want none", fill_addr_o);
        end else begin
          m_e = fq.pop_front();
          chk("fill_addr", LW'(fill_addr_o), LW'(m_e.addr));
          chk("fill_data", fill_data_o, m_e.data);
          chk("fill_src", LW'(fill_from_victim_o), LW'(m_e.src));
        end
      end
    end
  end

  initial begin
    #1;
    chk("rst_ready", LW'(miss_ready_o), 1);
    chk("rst_vwrite", LW'(victim_write_o), 0);
    chk("rst_vaddr", LW'(victim_addr_o), 0);
    chk("rst_fillv", LW'(fill_valid_o), 0);
    chk("rst_memreq", LW'(mem_req_o), 0);
    chk("rst_hits", LW'(hit_count_o), 0);
    chk("rst_miss", LW'(miss_count_o), 0);
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // Hit with eviction: fill in cycle +3, one victim write, no memory read.
    victim_hit_i = 1'b1; victim_data_i = V1; fill_ready_i = 1'b0;
    wq.push_back('{addr: 28'h0000456, data: E1, src: 1'b0});
    fq.push_back('{addr: 28'h0000123, data: V1, src: 1'b1});
    issue(28'h0000123, 1'b1, 28'h0000456, E1);
    chk("t1_probe_addr", LW'(victim_addr_o), 28'h0000123);
    chk("t1_fillv_c1", LW'(fill_valid_o), 0);
    chk("t1_vwrite_c1", LW'(victim_write_o), 0);
    cyc();
    chk("t1_vwrite_c2", LW'(victim_write_o), 1);
    chk("t1_fillv_c2", LW'(fill_valid_o), 0);
    cyc();
    chk("t1_fillv_c3", LW'(fill_valid_o), 1);
    chk("t1_src_c3", LW'(fill_from_victim_o), 1);
    chk("t1_vwrite_c3", LW'(victim_write_o), 0);
    fill_ready_i = 1'b1;
    cyc();
    fill_ready_i = 1'b0;
    chk("t1_ready", LW'(miss_ready_o), 1);
    chk("t1_hits", LW'(hit_count_o), 1);
    chk("t1_miss", LW'(miss_count_o), 0);
    chk("t1_memreq", LW'(n_memreq), 0);

    // Miss without eviction: memory ack 4 cycles after request; stray ack in PROBE ignored.
    victim_hit_i = 1'b0; victim_data_i = V3; fill_ready_i = 1'b1;
    fq.push_back('{addr: 28'h00000AA, data: DEAD, src: 1'b0});
    issue(28'h00000AA, 1'b0, '0, '0);
    mem_ack_i = 1'b1; mem_data_i = V1;
    cyc();
    mem_ack_i = 1'b0; mem_data_i = '0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_memreq", LW'(mem_req_o), 1);
      chk("t2_memaddr", LW'(mem_addr_o), 28'h00000AA);
      cyc();
    end
    mem_ack_i = 1'b1; mem_data_i = DEAD;
    cyc();
    mem_ack_i = 1'b0; mem_data_i = '0;
    chk("t2_fillv", LW'(fill_valid_o), 1);
    chk("t2_filldata", fill_data_o, DEAD);
    chk("t2_src", LW'(fill_from_victim_o), 0);
    cyc();
    chk("t2_memreq_n", LW'(n_memreq), 5);
    chk("t2_miss", LW'(miss_count_o), 1);
    chk("t2_ready", LW'(miss_ready_o), 1);

    // Fill back-pressure for 5 cycles; a new request is not taken meanwhile.
    victim_hit_i = 1'b1; victim_data_i = V3; fill_ready_i = 1'b0;
    fq.push_back('{addr: 28'h0000321, data: V3, src: 1'b1});
    issue(28'h0000321, 1'b0, '0, '0);
    cyc();
    miss_addr_i = 28'h0000999; miss_req_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_fillv", LW'(fill_valid_o), 1);
      chk("t3_filladdr", LW'(fill_addr_o), 28'h0000321);
      chk("t3_filldata", fill_data_o, V3);
      chk("t3_src", LW'(fill_from_victim_o), 1);
      chk("t3_ready", LW'(miss_ready_o), 0);
      cyc();
    end
    fill_ready_i = 1'b1;
    cyc();
    fill_ready_i = 1'b0; miss_req_i = 1'b0;
    chk("t3_ready_after", LW'(miss_ready_o), 1);
    cyc();
    chk("t3_still_idle", LW'(miss_ready_o), 1);
    chk("t3_hits", LW'(hit_count_o), 2);

    // Flush during MEM_REQ, then a late ack: no fill.
    victim_hit_i = 1'b0; fill_ready_i = 1'b1;
    issue(28'h0000055, 1'b0, '0, '0);
    cyc();
    chk("t4_memreq", LW'(mem_req_o), 1);
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    chk("t4_ready", LW'(miss_ready_o), 1);
    chk("t4_memreq_off", LW'(mem_req_o), 0);
    mem_ack_i = 1'b1; mem_data_i = DEAD;
    cyc();
    mem_ack_i = 1'b0; mem_data_i = '0;
    chk("t4_fillv", LW'(fill_valid_o), 0);
    chk("t4_ready2", LW'(miss_ready_o), 1);
    cyc();
    chk("t4_fillv2", LW'(fill_valid_o), 0);
    chk("t4_miss", LW'(miss_count_o), 2);

    // Flush and request in the same IDLE cycle: flush wins.
    flush_i = 1'b1; miss_req_i = 1'b1; miss_addr_i = 28'h0000099;
    cyc();
    flush_i = 1'b0; miss_req_i = 1'b0;
    chk("t5_ready", LW'(miss_ready_o), 1);
    cyc();
    chk("t5_hits", LW'(hit_count_o), 2);
    chk("t5_miss", LW'(miss_count_o), 2);

    // Hit counter wrap.
    for (int i = 0; i < (1 << SB) - 3; i++)
      do_hit(AW'(28'h0001000 + i), {4{32'h10000000 + 32'(i)}});
    chk("t6_hits_max", LW'(hit_count_o), (1 << SB) - 1);
    do_hit(28'h0002000, V1);
    chk("t6_hits_wrap", LW'(hit_count_o), 0);
    chk("t6_miss", LW'(miss_count_o), 2);

    // Reset pulse during EVICT aborts with no write and no fill.
    victim_hit_i = 1'b1; victim_data_i = V3; fill_ready_i = 1'b0;
    issue(28'h0000077, 1'b1, 28'h0000088, E1);
    cyc();
    #1;
    rst = 1'b1;
    #1;
    chk("t7_vwrite", LW'(victim_write_o), 0);
    chk("t7_ready", LW'(miss_ready_o), 1);
    chk("t7_hits", LW'(hit_count_o), 0);
    chk("t7_miss", LW'(miss_count_o), 0);
    chk("t7_fillv", LW'(fill_valid_o), 0);
    chk("t7_vaddr", LW'(victim_addr_o), 0);
    cyc();
    rst = 1'b0;
    cyc();
    chk("t7_fillv2", LW'(fill_valid_o), 0);
    do_hit(28'h0000321, V3);
    chk("t7_hits_after", LW'(hit_count_o), 1);

    cyc();
    chk("fill_q_empty", LW'(fq.size()), 0);
    chk("wr_q_empty", LW'(wq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
